forward_ctrl: RTL and testbench

FORWARD_CTRL -- requirements
Module: forward_ctrl

---
 rtl/forward_ctrl.sv | 77 +++++++
 tb/tb_forward_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/forward_ctrl.sv
// forward_ctrl: EX/MEM forwarding selects and load-use stall FSM for a 5-stage pipeline.
// Define FWD_STALL_STATS_EN to build the saturating stall_count counter.
module forward_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        id_valid,
   input  logic [4:0]  id_rn,
   input  logic [4:0]  id_rm,
   input  logic [4:0]  id_rd,
   input  logic        id_regwrite,
   input  logic        id_memread,
   input  logic        flush,
   output logic [1:0]  fwd_a_sel,
   output logic [1:0]  fwd_b_sel,
   output logic        stall,
   output logic        pc_write,
   output logic        ifid_write,
   output logic [31:0] stall_count
);
   typedef enum logic {RUN, STALL} state_t;
   state_t     r_state;
   logic       r_ex_v, r_ex_rw, r_ex_mr, r_mem_v, r_mem_rw;
   logic [4:0] r_ex_rd, r_mem_rd;
   logic       w_ex_wr, w_mem_wr, w_hazard, w_issue;
   assign w_ex_wr  = r_ex_v & r_ex_rw & (r_ex_rd != 5'd31);
   assign w_mem_wr = r_mem_v & r_mem_rw & (r_mem_rd != 5'd31);
   assign w_hazard = (r_state == RUN) & ~flush & id_valid & w_ex_wr & r_ex_mr &
                     ((id_rn == r_ex_rd) | (id_rm == r_ex_rd));
   assign w_issue  = id_valid & ~flush & ~w_hazard;
   function automatic logic [1:0] f_sel(input logic [4:0] r);
      return (r == 5'd31) ? 2'b00 :
             (w_ex_wr && r == r_ex_rd) ? 2'b01 :
             (w_mem_wr && r == r_mem_rd) ? 2'b10 : 2'b00;
   endfunction
   // The hazard edge inserts the bubble; the held ID instruction issues on the STALL edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= RUN;
         r_ex_v     <= 1'b0;
         r_ex_rw    <= 1'b0;
         r_ex_mr    <= 1'b0;
         r_ex_rd    <= 5'd0;
         r_mem_v    <= 1'b0;
         r_mem_rw   <= 1'b0;
         r_mem_rd   <= 5'd0;
         fwd_a_sel  <= 2'b00;
         fwd_b_sel  <= 2'b00;
         stall      <= 1'b0;
         pc_write   <= 1'b1;
         ifid_write <= 1'b1;
      end else begin
         r_state    <= w_hazard ? STALL : RUN;
         r_mem_v    <= r_ex_v;
         r_mem_rw   <= r_ex_rw;
         r_mem_rd   <= r_ex_rd;
         r_ex_v     <= w_issue;
         r_ex_rw    <= id_regwrite;
         r_ex_mr    <= id_memread;
         r_ex_rd    <= id_rd;
         fwd_a_sel  <= w_issue ? f_sel(id_rn) : 2'b00;
         fwd_b_sel  <= w_issue ? f_sel(id_rm) : 2'b00;
         stall      <= w_hazard;
         pc_write   <= ~w_hazard;
         ifid_write <= ~w_hazard;
      end
   end
`ifdef FWD_STALL_STATS_EN
   logic [31:0] r_stall_count;
   always_ff @(posedge clk) begin
      if (reset) r_stall_count <= '0;
      else if (r_state == STALL && r_stall_count != 32'hFFFF_FFFF) r_stall_count <= r_stall_count + 32'd1;
   end
   assign stall_count = r_stall_count;
`else
   assign stall_count = '0;
`endif
endmodule

// File: tb/tb_forward_ctrl.sv
// tb_forward_ctrl: directed and randomized checks of forward_ctrl against a pipeline-history model.
module tb_forward_ctrl;
   logic        clk = 1'b0;
   logic        reset = 1'b1, id_valid = 1'b0, id_regwrite = 1'b0, id_memread = 1'b0, flush = 1'b0;
   logic [4:0]  id_rn = '0, id_rm = '0, id_rd = '0;
   logic [1:0]  fwd_a_sel, fwd_b_sel;
   logic        stall, pc_write, ifid_write;
   logic [31:0] stall_count;
   logic [6:0]  w_obs;
   int          pass = 0, total = 0;
   logic [7:0]  hist[$];
   logic [1:0]  m_a, m_b;
   logic        m_stall;
   logic [31:0] m_cnt;

   forward_ctrl dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
      .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall), .pc_write(pc_write),
      .ifid_write(ifid_write), .stall_count(stall_count)
   );

   always #5 clk = ~clk;
   assign w_obs = {fwd_a_sel, fwd_b_sel, stall, pc_write, ifid_write};

   function automatic logic [1:0] msel(input logic [4:0] r, input logic [7:0] ex, input logic [7:0] mem);
      if (r == 5'd31) return 2'd0;
      if (ex[7] && ex[6] && ex[4:0] == r) return 2'd1;
      if (mem[7] && mem[6] && mem[4:0] == r) return 2'd2;
      return 2'd0;
   endfunction

   // History holds {valid, regwrite, memread, rd} of what entered EX each cycle.
   task automatic mstep();
      logic [7:0] ex, mem;
      logic haz, ins;
      if (reset) begin
         hist = {8'h00, 8'h00};
         m_a = 0; m_b = 0; m_stall = 0; m_cnt = 0;
      end else begin
         ex  = hist[hist.size()-1];
         mem = hist[hist.size()-2];
         haz = !flush && !m_stall && id_valid && ex[7] && ex[6] && ex[5] && ex[4:0] != 5'd31 &&
               (id_rn == ex[4:0] || id_rm == ex[4:0]);
         ins = id_valid && !flush && !haz;
`ifdef FWD_STALL_STATS_EN
         if (m_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
`endif
         m_a = ins ? msel(id_rn, ex, mem) : 2'd0;
         m_b = ins ? msel(id_rm, ex, mem) : 2'd0;
         m_stall = haz;
         hist.push_back(ins ? {1'b1, id_regwrite, id_memread, id_rd} : 8'h00);
         if (hist.size() > 3) hist.pop_front();
      end
   endtask

   task automatic tick();
      mstep();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                         input logic [4:0] rd, input logic rw, input logic mr);
      id_valid = v; id_rn = rn; id_rm = rm; id_rd = rd; id_regwrite = rw; id_memread = mr;
   endtask

   task automatic test_reset();
      reset = 1; flush = 1; set_id(1, 1, 1, 1, 1, 1);
      tick(); tick();
      total++;
      if (w_obs !== 7'b00_00_0_11) $display("FAIL reset outputs got %b want 0000011", w_obs);
      else pass++;
      total++;
      if (stall_count !== 32'd0) $display("FAIL reset stall_count got %0d want 0", stall_count);
      else pass++;
      reset = 0; flush = 0; set_id(0, 0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_ex_fwd();
      set_id(1, 5, 6, 1, 1, 0); tick();
      set_id(1, 1, 7, 9, 1, 0); tick();
      total++;
      if (w_obs !== 7'b01_00_0_11) $display("FAIL ex_fwd got %b want 0100011", w_obs);
      else pass++;
   endtask

   task automatic test_mem_fwd();
      set_id(1, 4, 5, 2, 1, 0); tick();
      set_id(1, 6, 7, 8, 1, 0); tick();
      set_id(1, 10, 2, 11, 1, 0); tick();
      total++;
      if (w_obs !== 7'b00_10_0_11) $display("FAIL mem_fwd got %b want 0010011", w_obs);
      else pass++;
      set_id(1, 4, 5, 2, 1, 0); tick(); tick();
      set_id(1, 10, 2, 11, 1, 0); tick();
      total++;
      if (w_obs !== 7'b00_01_0_11) $display("FAIL ex_over_mem got %b want 0001011", w_obs);
      else pass++;
   endtask

   task automatic test_load_use();
      set_id(1, 20, 21, 3, 1, 1); tick();
      set_id(1, 3, 12, 13, 1, 0); tick();
      total++;
      if (w_obs !== 7'b00_00_1_00) $display("FAIL load_use stall got %b want 0000100", w_obs);
      else pass++;
      tick();
      total++;
      if (w_obs !== 7'b10_00_0_11) $display("FAIL load_use resume got %b want 1000011", w_obs);
      else pass++;
   endtask

   task automatic test_xzr();
      set_id(1, 1, 2, 31, 1, 0); tick();
      set_id(1, 31, 31, 5, 1, 0); tick();
      total++;
      if (w_obs !== 7'b00_00_0_11) $display("FAIL xzr_alu got %b want 0000011", w_obs);
      else pass++;
      set_id(1, 0, 0, 31, 1, 1); tick();
      set_id(1, 31, 31, 6, 1, 0); tick();
      total++;
      if (w_obs !== 7'b00_00_0_11) $display("FAIL xzr_load got %b want 0000011", w_obs);
      else pass++;
   endtask

   task automatic test_flush_stall();
      set_id(1, 20, 21, 4, 1, 1); tick();
      set_id(1, 22, 4, 14, 1, 0); tick();
      total++;
      if (w_obs !== 7'b00_00_1_00) $display("FAIL flush_pre stall got %b want 0000100", w_obs);
      else pass++;
      flush = 1; tick(); flush = 0;
      total++;
      if (w_obs !== 7'b00_00_0_11) $display("FAIL flush_stall got %b want 0000011", w_obs);
      else pass++;
   endtask

   task automatic test_stats();
      logic [31:0] exp3;
`ifdef FWD_STALL_STATS_EN
      exp3 = 32'd3;
`else
      exp3 = 32'd0;
`endif
      reset = 1; tick(); reset = 0;
      for (int i = 0; i < 3; i++) begin
         set_id(1, 20, 21, 5, 1, 1); tick();
         set_id(1, 5, 22, 23, 1, 0); tick(); tick();
      end
      total++;
      if (stall_count !== exp3) $display("FAIL stats_three got %0d want %0d", stall_count, exp3);
      else pass++;
      set_id(1, 20, 21, 5, 1, 1); tick();
      set_id(1, 5, 22, 23, 1, 0); tick();
      reset = 1; tick(); reset = 0;
      total++;
      if (stall_count !== 32'd0 || w_obs !== 7'b00_00_0_11)
         $display("FAIL stats_reset got cnt=%0d obs=%b want 0 0000011", stall_count, w_obs);
      else pass++;
   endtask

   task automatic test_random();
      int r;
      reset = 1; tick(); reset = 0;
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 49) == 0);
         flush = ($urandom_range(0, 7) == 0);
         r = $urandom_range(0, 4); id_rn = (r == 4) ? 5'd31 : 5'(r);
         r = $urandom_range(0, 4); id_rm = (r == 4) ? 5'd31 : 5'(r);
         r = $urandom_range(0, 4); id_rd = (r == 4) ? 5'd31 : 5'(r);
         id_valid = ($urandom_range(0, 4) != 0);
         id_regwrite = $urandom_range(0, 1) == 1;
         id_memread = $urandom_range(0, 2) == 0;
         tick();
         total++;
         if (w_obs !== {m_a, m_b, m_stall, !m_stall, !m_stall} || stall_count !== m_cnt)
            $display("FAIL random[%0d] got obs=%b cnt=%0d want obs=%b cnt=%0d", i, w_obs, stall_count,
                     {m_a, m_b, m_stall, !m_stall, !m_stall}, m_cnt);
         else pass++;
      end
      reset = 0; flush = 0;
   endtask

   initial begin
      test_reset();
      test_ex_fwd();
      test_mem_fwd();
      test_load_use();
      test_xzr();
      test_flush_stall();
      test_stats();
      test_random();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
